rv_seven_digit_ctrl: RTL and testbench

// - Memory-mapped 7-segment display controller on the data-memory bus; successor of the single-register hex device.
// - Parametrised digit count and segment polarity.
// - Adds per-digit blanking, byte-enable writes, register read-back and a one-cycle rvalid pulse for every accepted access.
// - Optional per-digit blinking from a programmable prescaler.
// - Drives board HEX displays directly (static, non-multiplexed).

---
 rtl/rv_pkg.sv | 32 +++
 rtl/rv_seven_digit_ctrl_if.sv | 23 ++
 rtl/seven_digit_driver.sv | 30 +++
 rtl/rv_seven_digit_ctrl.sv | 136 +++++++++++++
 tb/tb_rv_seven_digit_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the memory-mapped hex display: bus width, register window and offsets.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ADDRESS_HEX = 32'h8000_2000;

  localparam logic [3:0] HEX_OFS_DATA      = 4'h0;
  localparam logic [3:0] HEX_OFS_BLANK     = 4'h4;
  localparam logic [3:0] HEX_OFS_BLINK_MSK = 4'h8;
  localparam logic [3:0] HEX_OFS_BLINK_PER = 4'hC;

  typedef enum logic [3:0] {
    HEX_REG_DATA      = HEX_OFS_DATA,
    HEX_REG_BLANK     = HEX_OFS_BLANK,
    HEX_REG_BLINK_MSK = HEX_OFS_BLINK_MSK,
    HEX_REG_BLINK_PER = HEX_OFS_BLINK_PER
  } hex_reg_e;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [XLEN-1:0] be_merge(input logic [XLEN-1:0]   old_val,
                                                input logic [XLEN-1:0]   wdata,
                                                input logic [XLEN/8-1:0] be);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int k = 0; k < XLEN/8; k++) begin
      if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_seven_digit_ctrl_if.sv
// Data-memory bus bundle as seen by the hex display controller.
interface rv_seven_digit_ctrl_if;
  import rv_pkg::*;

  logic              data_req;
  logic              data_we;
  logic [XLEN/8-1:0] data_be;
  logic [XLEN-1:0]   data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic              data_rvalid;
  logic [XLEN-1:0]   data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_rvalid, data_rdata
  );

endinterface

// File: rtl/seven_digit_driver.sv
// Hex nibble to 7-segment decoder; output is active-low, bit0=a .. bit6=g.
module seven_digit_driver (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/rv_seven_digit_ctrl.sv
// Memory-mapped static 7-segment controller with blanking and read-back.
// Per-digit blinking is built only when RV_HEX_BLINK_EN is defined.
module rv_seven_digit_ctrl
  import rv_pkg::*;
#(
  parameter int NDIGITS    = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_W    = 24
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  rv_seven_digit_ctrl_if.slave   bus,
  output logic [7*NDIGITS-1:0]   hex_o
);

  localparam int         DW        = 4*NDIGITS;
  localparam logic [6:0] SEG_DARK  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_ZERO  = ACTIVE_LOW ? 7'h40 : 7'h3F;

  logic                  accept;
  logic                  wr;
  hex_reg_e              reg_sel;
  logic [DW-1:0]         data_q;
  logic [NDIGITS-1:0]    blank_q;
  logic [NDIGITS-1:0]    msk_q;
  logic [BLINK_W-1:0]    per_q;
  logic                  phase;
  logic [XLEN-1:0]       rd_val;
  logic [7*NDIGITS-1:0]  hex_d;
  logic                  vld_p1;
  logic [XLEN-1:0]       rdata_p1;
  logic [7*NDIGITS-1:0]  hex_p1;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^bus.data_addr[1:0];
  assign accept  = bus.data_req && (bus.data_addr[XLEN-1:4] == ADDRESS_HEX[XLEN-1:4]);
  assign wr      = accept && bus.data_we;
  assign reg_sel = hex_reg_e'({bus.data_addr[3:2], 2'b00});

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      data_q  <= '0;
      blank_q <= '0;
    end else if (wr) begin
      case (reg_sel)
        HEX_REG_DATA:  data_q  <= DW'(be_merge(XLEN'(data_q), bus.data_wdata, bus.data_be));
        HEX_REG_BLANK: blank_q <= NDIGITS'(be_merge(XLEN'(blank_q), bus.data_wdata, bus.data_be));
        default: ;
      endcase
    end
  end

`ifdef RV_HEX_BLINK_EN
  logic [BLINK_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      msk_q <= '0;
      per_q <= '0;
    end else if (wr) begin
      case (reg_sel)
        HEX_REG_BLINK_MSK: msk_q <= NDIGITS'(be_merge(XLEN'(msk_q), bus.data_wdata, bus.data_be));
        HEX_REG_BLINK_PER: per_q <= BLINK_W'(be_merge(XLEN'(per_q), bus.data_wdata, bus.data_be));
        default: ;
      endcase
    end
  end

  // A BLINK_PER write restarts the half-period so the new rate begins lit.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (wr && reg_sel == HEX_REG_BLINK_PER) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (per_q == '0) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (cnt_q == per_q - BLINK_W'(1)) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + BLINK_W'(1);
    end
  end
`else
  assign msk_q = '0;
  assign per_q = '0;
  assign phase = 1'b1;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      HEX_REG_DATA:      rd_val = XLEN'(data_q);
      HEX_REG_BLANK:     rd_val = XLEN'(blank_q);
      HEX_REG_BLINK_MSK: rd_val = XLEN'(msk_q);
      HEX_REG_BLINK_PER: rd_val = XLEN'(per_q);
      default:           rd_val = '0;
    endcase
  end

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    logic [6:0] seg_raw;
    logic [6:0] seg_lit;
    logic       dark;

    seven_digit_driver u_drv (
      .digit (data_q[4*i +: 4]),
      .seg   (seg_raw)
    );

    assign seg_lit           = ACTIVE_LOW ? seg_raw : ~seg_raw;
    assign dark              = blank_q[i] | (msk_q[i] & ~phase);
    assign hex_d[7*i +: 7]   = dark ? SEG_DARK : seg_lit;
  end

  // ---- stage p1: bus response and registered segment drive ----
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      hex_p1   <= {NDIGITS{SEG_ZERO}};
    end else begin
      vld_p1   <= accept;
      rdata_p1 <= (accept && !bus.data_we) ? rd_val : '0;
      hex_p1   <= hex_d;
    end
  end

  assign bus.data_rvalid = vld_p1;
  assign bus.data_rdata  = rdata_p1;
  assign hex_o           = hex_p1;

endmodule

// File: tb/tb_rv_seven_digit_ctrl.sv
// Self-checking bench for rv_seven_digit_ctrl: vector table plus response scoreboard.
module tb_rv_seven_digit_ctrl;
  import rv_pkg::*;

`ifdef RV_HEX_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [3:0]  ofs;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          chk_hex;
  } vec_t;

  logic        clk = 1'b0;
  logic        arstn;
  logic [55:0] hex;
  logic [27:0] hex4;

  always #5 clk = ~clk;

  rv_seven_digit_ctrl_if bus ();
  rv_seven_digit_ctrl_if bus4 ();

  rv_seven_digit_ctrl #(.NDIGITS(8), .ACTIVE_LOW(1'b1), .BLINK_W(24)) dut (
    .clk_i (clk), .arstn_i (arstn), .bus (bus), .hex_o (hex)
  );

  rv_seven_digit_ctrl #(.NDIGITS(4), .ACTIVE_LOW(1'b0), .BLINK_W(8)) dut4 (
    .clk_i (clk), .arstn_i (arstn), .bus (bus4), .hex_o (hex4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  int          b2b = 0;
  bit          prev_rv = 1'b0;
  logic [31:0] m_data;
  logic [7:0]  m_blank;
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] d, input logic [7:0] b);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = b[i] ? 7'h7F : seg7(d[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (arstn === 1'b1) begin
      if (bus.data_rvalid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid got rvalid=1 expected 0 at %0t", $time);
        end else begin
          chk("rdata", 64'(bus.data_rdata), 64'(sb_q.pop_front()));
        end
        if (prev_rv) b2b++;
      end else begin
        chk("rdata_idle", 64'(bus.data_rdata), 64'h0);
      end
      prev_rv = (bus.data_rvalid === 1'b1);
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic acc(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input bit resp, input logic [31:0] exp_rd);
    @(negedge clk);
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    bus.data_be    = be;
    if (resp) sb_q.push_back(we ? 32'h0 : exp_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_req = 1'b0;
      bus.data_we  = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [6:0] d0, lit, prev_d0;
    int toggles, last, bad, b2b_before;

    vecs[0]  = '{1'b1, 4'h0, 32'h89ABCDEF, 4'hF, 32'h0,        1'b1};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h89ABCDEF, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h4, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h12FF5678, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 32'hAAAABBBB, 4'h3, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h12FFBBBB, 1'b0};
    vecs[7]  = '{1'b1, 4'h4, 32'hFFFFFF05, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00000005, 1'b0};
    vecs[9]  = '{1'b1, 4'h4, 32'h000000FF, 4'h1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h000000FF, 1'b0};
    vecs[11] = '{1'b1, 4'h4, 32'h00000000, 4'hF, 32'h0,        1'b1};

    arstn = 1'b0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_be = '0; bus.data_addr = '0; bus.data_wdata = '0;
    bus4.data_req = 1'b0; bus4.data_we = 1'b0; bus4.data_be = '0; bus4.data_addr = '0; bus4.data_wdata = '0;
    m_data = '0;
    m_blank = '0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("reset_hex", 64'(hex), 64'({8{7'h40}}));
    chk("reset_digit0", 64'(hex[6:0]), 64'(7'b1000000));
    chk("reset_rvalid", 64'(bus.data_rvalid), 64'h0);
    chk("reset_hex4", 64'(hex4), 64'({4{7'h3F}}));

    for (int i = 0; i < 12; i++) begin
      acc(vecs[i].we, ADDRESS_HEX + {28'h0, vecs[i].ofs}, vecs[i].wd, vecs[i].be, 1'b1, vecs[i].exp_rd);
      if (vecs[i].we) begin
        if (vecs[i].ofs == 4'h0) m_data = merge(m_data, vecs[i].wd, vecs[i].be);
        else m_blank = 8'(merge({24'h0, m_blank}, vecs[i].wd, vecs[i].be));
      end
      idle(3);
      if (vecs[i].chk_hex) chk("hex_vec", 64'(hex), 64'(exp_hex(m_data, m_blank)));
      if (i == 0) begin
        chk("digit0_F", 64'(hex[6:0]), 64'(7'h0E));
        chk("digit7_8", 64'(hex[55:49]), 64'(7'h00));
      end
      if (i == 7) begin
        chk("blank_d0", 64'(hex[6:0]), 64'(7'h7F));
        chk("blank_d2", 64'(hex[20:14]), 64'(7'h7F));
        chk("blank_d1", 64'(hex[13:7]), 64'(seg7(m_data[7:4])));
      end
    end

    // back-to-back read then write
    b2b_before = b2b;
    acc(1'b0, ADDRESS_HEX, 32'h0, 4'hF, 1'b1, m_data);
    acc(1'b1, ADDRESS_HEX + 32'h4, 32'h00000005, 4'h1, 1'b1, 32'h0);
    m_blank = 8'h05;
    idle(3);
    chk("b2b_pulses", 64'(b2b - b2b_before), 64'd1);
    chk("b2b_hex", 64'(hex), 64'(exp_hex(m_data, m_blank)));
    acc(1'b1, ADDRESS_HEX + 32'h4, 32'h0, 4'hF, 1'b1, 32'h0);
    m_blank = 8'h00;
    idle(3);

    // outside the window: no response, no state change
    acc(1'b0, ADDRESS_HEX + 32'h10, 32'h0, 4'hF, 1'b0, 32'h0);
    idle(1);
    chk("oow_rd_rvalid", 64'(bus.data_rvalid), 64'h0);
    acc(1'b1, ADDRESS_HEX + 32'h10, 32'h0, 4'hF, 1'b0, 32'h0);
    idle(1);
    chk("oow_wr_rvalid", 64'(bus.data_rvalid), 64'h0);
    idle(2);
    chk("oow_hex", 64'(hex), 64'(exp_hex(m_data, m_blank)));
    acc(1'b0, ADDRESS_HEX, 32'h0, 4'hF, 1'b1, m_data);
    idle(2);

    // blink registers
    lit = seg7(m_data[3:0]);
    acc(1'b1, ADDRESS_HEX + 32'hC, 32'd4, 4'hF, 1'b1, 32'h0);
    acc(1'b1, ADDRESS_HEX + 32'h8, 32'h1, 4'hF, 1'b1, 32'h0);
    idle(2);
    acc(1'b0, ADDRESS_HEX + 32'hC, 32'h0, 4'hF, 1'b1, BLINK_ON ? 32'd4 : 32'd0);
    acc(1'b0, ADDRESS_HEX + 32'h8, 32'h0, 4'hF, 1'b1, BLINK_ON ? 32'h1 : 32'h0);
    idle(2);
    toggles = 0; last = -1; bad = 0;
    prev_d0 = hex[6:0];
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      d0 = hex[6:0];
      if (d0 !== lit && (d0 !== 7'h7F || !BLINK_ON)) bad++;
      if (d0 !== prev_d0) begin
        if (last >= 0) chk("blink_run", 64'(c - last), 64'd4);
        last = c;
        toggles++;
      end
      prev_d0 = d0;
    end
    chk("blink_bad", 64'(bad), 64'd0);
    chk("blink_toggles", 64'(toggles >= 4), BLINK_ON ? 64'd1 : 64'd0);
    chk("blink_others", 64'(hex[55:7]), 64'(exp_hex(m_data, m_blank) >> 7));

    acc(1'b1, ADDRESS_HEX + 32'hC, 32'd0, 4'hF, 1'b1, 32'h0);
    idle(3);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (hex[6:0] !== lit) bad++;
    end
    chk("per0_steady", 64'(bad), 64'd0);
    acc(1'b1, ADDRESS_HEX + 32'h8, 32'h0, 4'hF, 1'b1, 32'h0);
    idle(2);

    // narrow instance: unimplemented BLANK bits read 0, active-high dark
    @(negedge clk);
    bus4.data_req = 1'b1; bus4.data_we = 1'b1; bus4.data_be = 4'hF;
    bus4.data_addr = ADDRESS_HEX + 32'h4; bus4.data_wdata = 32'h000000FF;
    @(negedge clk);
    bus4.data_we = 1'b0;
    chk("n4_wr_rvalid", 64'(bus4.data_rvalid), 64'h1);
    chk("n4_wr_rdata", 64'(bus4.data_rdata), 64'h0);
    @(negedge clk);
    bus4.data_req = 1'b0;
    chk("n4_rd_rvalid", 64'(bus4.data_rvalid), 64'h1);
    chk("n4_rd_blank", 64'(bus4.data_rdata), 64'h0000000F);
    @(negedge clk);
    chk("n4_idle_rvalid", 64'(bus4.data_rvalid), 64'h0);
    repeat (2) @(negedge clk);
    chk("n4_dark", 64'(hex4), 64'h0);

    // reset while a response is pending
    acc(1'b0, ADDRESS_HEX, 32'h0, 4'hF, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    arstn = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(bus.data_rvalid), 64'h0);
    @(negedge clk);
    arstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_post_rvalid", 64'(bus.data_rvalid), 64'h0);
    end
    chk("rst_post_hex", 64'(hex), 64'({8{7'h40}}));
    acc(1'b0, ADDRESS_HEX, 32'h0, 4'hF, 1'b1, 32'h0);
    idle(3);

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
